pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the HiSEP-Q instruction fetch path, succeeding the single-mode PC generator. It adds an explicit IDLE/RUN/HALT state machine, a fetch stall, configurable PC width and step, and a hardware return-address stack for call/return. It sits between the controller's start/end handshake and the instruction memory address port, and takes branch targets from the ALU.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the controller/ALU and pc_sequencer.
// The controller side drives the master modport; the sequencer is the slave.
interface pc_sequencer_if #(
   parameter int unsigned PC_W = 64
);
   logic            start;
   logic            end_req;
   logic            stall;
   logic            br_taken;
   logic            call;
   logic            ret;
   logic [PC_W-1:0] br_target;
   logic [PC_W-1:0] pc;
   logic            pc_valid;
   logic            halted;
   logic            ras_ovf;
   logic            ras_unf;

   modport master (
      output start, end_req, stall, br_taken, call, ret, br_target,
      input  pc, pc_valid, halted, ras_ovf, ras_unf
   );

   modport slave (
      input  start, end_req, stall, br_taken, call, ret, br_target,
      output pc, pc_valid, halted, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with IDLE/RUN/HALT control and fetch stall.
// Define PC_SEQ_RAS_EN to build the return-address stack and its sticky flags.
module pc_sequencer #(
   parameter int unsigned     PC_W      = 64,
   parameter int unsigned     STEP      = 1,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int unsigned     RAS_DEPTH = 8
) (
   input logic           clk,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_e;

   localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pcInc;
   logic            pcValid_q;
   logic            halted_q;
   logic            restart;
   logic            doRet;
   logic            doCall;

   assign pcInc = pc_q + STEP_V;

`ifdef PC_SEQ_RAS_EN
   localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
   localparam int unsigned SP_W  = IDX_W + 1;

   logic [PC_W-1:0] stack_q [RAS_DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic [PC_W-1:0] stackTop;
   logic            push;
   logic            rasOvf_q, rasOvf_d;
   logic            rasUnf_q, rasUnf_d;

   assign stackTop = stack_q[IDX_W'(sp_q - SP_W'(1))];
`endif

   // Control decision: end_req beats start beats stall beats ret beats call beats branch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      restart = 1'b0;
      doRet   = 1'b0;
      doCall  = 1'b0;
      case (state_q)
         IDLE: restart = bus.start;
         RUN: begin
            if (bus.end_req) begin
               state_d = HALT;
            end else if (bus.start) begin
               restart = 1'b1;
            end else if (!bus.stall) begin
               if (bus.ret) begin
                  doRet = 1'b1;
               end else if (bus.call) begin
                  doCall = 1'b1;
               end else if (bus.br_taken) begin
                  pc_d = bus.br_target;
               end else begin
                  pc_d = pcInc;
               end
            end
         end
         HALT: restart = bus.start;
         default: state_d = IDLE;
      endcase
      if (restart) begin
         state_d = RUN;
         pc_d    = RESET_PC;
      end
`ifdef PC_SEQ_RAS_EN
      sp_d     = sp_q;
      push     = 1'b0;
      rasOvf_d = rasOvf_q;
      rasUnf_d = rasUnf_q;
      if (restart) begin
         sp_d     = '0;
         rasOvf_d = 1'b0;
         rasUnf_d = 1'b0;
      end
      if (doRet) begin
         if (sp_q == '0) begin
            pc_d     = pcInc;
            rasUnf_d = 1'b1;
         end else begin
            pc_d = stackTop;
            sp_d = sp_q - SP_W'(1);
         end
      end
      // A call on a full stack still jumps; only the return address is lost.
      if (doCall) begin
         pc_d = bus.br_target;
         if (sp_q == SP_W'(RAS_DEPTH)) begin
            rasOvf_d = 1'b1;
         end else begin
            push = 1'b1;
            sp_d = sp_q + SP_W'(1);
         end
      end
`else
      if (doRet) begin
         pc_d = pcInc;
      end
      if (doCall) begin
         pc_d = bus.br_target;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         pcValid_q <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pcValid_q <= (state_d == RUN);
         halted_q  <= (state_d == HALT);
      end
   end

`ifdef PC_SEQ_RAS_EN
   // Stack entries need no reset; the pointer alone defines what is valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q     <= '0;
         rasOvf_q <= 1'b0;
         rasUnf_q <= 1'b0;
      end else begin
         sp_q     <= sp_d;
         rasOvf_q <= rasOvf_d;
         rasUnf_q <= rasUnf_d;
         if (push) begin
            stack_q[sp_q[IDX_W-1:0]] <= pcInc;
         end
      end
   end

   assign bus.ras_ovf = rasOvf_q;
   assign bus.ras_unf = rasUnf_q;
`else
   assign bus.ras_ovf = 1'b0;
   assign bus.ras_unf = 1'b0;
`endif

   assign bus.pc       = pc_q;
   assign bus.pc_valid = pcValid_q;
   assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer: a 64-bit default instance and an 8-bit wrap instance.
// Stack expectations switch on PC_SEQ_RAS_EN so the bench matches either build.
module tb_pc_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   nCompared   = 0;
   int   nMismatched = 0;

`ifdef PC_SEQ_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   always #5 clk = ~clk;

   pc_sequencer_if #(.PC_W(64)) bus ();
   pc_sequencer_if #(.PC_W(8))  bus8 ();

   pc_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   pc_sequencer #(
      .PC_W      (8),
      .STEP      (1),
      .RESET_PC  (8'h10),
      .RAS_DEPTH (4)
   ) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   // Drive one cycle of controls on the 64-bit instance, then sample 1 time unit after the edge.
   task automatic applyStimulus(input logic s, input logic e, input logic st, input logic b,
                                input logic c, input logic r, input logic [63:0] tgt);
      bus.start = s; bus.end_req = e; bus.stall = st;
      bus.br_taken = b; bus.call = c; bus.ret = r; bus.br_target = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus8(input logic s, input logic e, input logic st, input logic b,
                                 input logic c, input logic r, input logic [7:0] tgt);
      bus8.start = s; bus8.end_req = e; bus8.stall = st;
      bus8.br_taken = b; bus8.call = c; bus8.ret = r; bus8.br_target = tgt;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      reset = 1'b0;
      nCompared++;
      if (bus.pc !== 64'h0) begin
         nMismatched++; $display("[TB] FAIL reset_pc: got %h want %h", bus.pc, 64'h0);
      end
      nCompared++;
      if ({bus.pc_valid, bus.halted, bus.ras_ovf, bus.ras_unf} !== 4'b0000) begin
         nMismatched++; $display("[TB] FAIL reset_status: got %b want 0000",
                                 {bus.pc_valid, bus.halted, bus.ras_ovf, bus.ras_unf});
      end
      applyStimulus(0, 0, 0, 1, 1, 1, 64'h55);
      nCompared++;
      if ({bus.pc, bus.pc_valid} !== {64'h0, 1'b0}) begin
         nMismatched++; $display("[TB] FAIL idle_ignore: got pc %h valid %b want 0 0", bus.pc, bus.pc_valid);
      end
   endtask

   task automatic test_run();
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if ({bus.pc, bus.pc_valid, bus.halted} !== {64'h0, 2'b10}) begin
         nMismatched++; $display("[TB] FAIL start: got pc %h valid %b halted %b want 0 1 0",
                                 bus.pc, bus.pc_valid, bus.halted);
      end
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
         nCompared++;
         if ({bus.pc, bus.pc_valid} !== {64'(i), 1'b1}) begin
            nMismatched++; $display("[TB] FAIL run_inc%0d: got pc %h valid %b want %h 1",
                                    i, bus.pc, bus.pc_valid, 64'(i));
         end
      end
   endtask

   task automatic test_branch_stall();
      logic [63:0] expPc [4] = '{64'h40, 64'h40, 64'h40, 64'h41};
      logic        stallV [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic        brV [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, stallV[i], brV[i], 0, 0, 64'h40);
         nCompared++;
         if (bus.pc !== expPc[i]) begin
            nMismatched++; $display("[TB] FAIL branch_stall%0d: got %h want %h", i, bus.pc, expPc[i]);
         end
      end
   endtask

   task automatic test_call_ret();
      logic [63:0] retPc;
      retPc = RAS ? 64'h6 : 64'h103;
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if (bus.pc !== 64'h5) begin
         nMismatched++; $display("[TB] FAIL call_setup: got %h want %h", bus.pc, 64'h5);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 64'h100);
      nCompared++;
      if (bus.pc !== 64'h100) begin
         nMismatched++; $display("[TB] FAIL call_jump: got %h want %h", bus.pc, 64'h100);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if (bus.pc !== 64'h102) begin
         nMismatched++; $display("[TB] FAIL call_body: got %h want %h", bus.pc, 64'h102);
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 64'h0);
      nCompared++;
      if (bus.pc !== retPc) begin
         nMismatched++; $display("[TB] FAIL ret_pc: got %h want %h", bus.pc, retPc);
      end
      nCompared++;
      if ({bus.ras_ovf, bus.ras_unf} !== 2'b00) begin
         nMismatched++; $display("[TB] FAIL ret_flags: got %b want 00", {bus.ras_ovf, bus.ras_unf});
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] expPc [4];
      logic        callV [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic        brV [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic        retV [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [63:0] tgtV [4] = '{64'h10, 64'h20, 64'h30, 64'h0};
      expPc = '{64'h10, 64'h20, 64'h30, RAS ? 64'h21 : 64'h31};
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, brV[i], callV[i], retV[i], tgtV[i]);
         nCompared++;
         if (bus.pc !== expPc[i]) begin
            nMismatched++; $display("[TB] FAIL b2b%0d: got %h want %h", i, bus.pc, expPc[i]);
         end
      end
   endtask

`ifdef PC_SEQ_RAS_EN
   task automatic test_ras();
      logic [63:0] pushed [8];
      logic [63:0] expPc;
      logic [63:0] tgt;
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      expPc = 64'h0;
      for (int k = 1; k <= 9; k++) begin
         tgt = 64'h1000 + 64'((k - 1) * 16);
         if (k <= 8) pushed[k-1] = expPc + 64'h1;
         expPc = tgt;
         applyStimulus(0, 0, 0, 0, 1, 0, tgt);
         nCompared++;
         if ({bus.pc, bus.ras_ovf} !== {expPc, (k == 9)}) begin
            nMismatched++; $display("[TB] FAIL call%0d: got pc %h ovf %b want %h %b",
                                    k, bus.pc, bus.ras_ovf, expPc, (k == 9));
         end
      end
      for (int j = 8; j >= 1; j--) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 64'h0);
         nCompared++;
         if ({bus.pc, bus.ras_unf} !== {pushed[j-1], 1'b0}) begin
            nMismatched++; $display("[TB] FAIL ret%0d: got pc %h unf %b want %h 0",
                                    j, bus.pc, bus.ras_unf, pushed[j-1]);
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 64'h0);
      nCompared++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== {64'h2, 2'b11}) begin
         nMismatched++; $display("[TB] FAIL ret_empty: got pc %h flags %b want 2 11",
                                 bus.pc, {bus.ras_ovf, bus.ras_unf});
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== {64'h0, 2'b00}) begin
         nMismatched++; $display("[TB] FAIL restart_clear: got pc %h flags %b want 0 00",
                                 bus.pc, {bus.ras_ovf, bus.ras_unf});
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 64'h300);
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 1, 64'h0);
      nCompared++;
      if ({bus.pc, bus.ras_unf} !== {64'h3, 1'b1}) begin
         nMismatched++; $display("[TB] FAIL stack_cleared: got pc %h unf %b want 3 1", bus.pc, bus.ras_unf);
      end
   endtask
`else
   task automatic test_ras();
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 64'h20);
      nCompared++;
      if (bus.pc !== 64'h20) begin
         nMismatched++; $display("[TB] FAIL noras_call: got %h want %h", bus.pc, 64'h20);
      end
      applyStimulus(0, 0, 0, 0, 0, 1, 64'h0);
      nCompared++;
      if ({bus.pc, bus.ras_ovf, bus.ras_unf} !== {64'h21, 2'b00}) begin
         nMismatched++; $display("[TB] FAIL noras_ret: got pc %h flags %b want 21 00",
                                 bus.pc, {bus.ras_ovf, bus.ras_unf});
      end
   endtask
`endif

   task automatic test_halt();
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      applyStimulus(1, 1, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if ({bus.pc, bus.pc_valid, bus.halted} !== {64'h2, 2'b01}) begin
         nMismatched++; $display("[TB] FAIL end_req: got pc %h valid %b halted %b want 2 0 1",
                                 bus.pc, bus.pc_valid, bus.halted);
      end
      applyStimulus(0, 1, 0, 1, 1, 0, 64'h77);
      nCompared++;
      if ({bus.pc, bus.pc_valid, bus.halted} !== {64'h2, 2'b01}) begin
         nMismatched++; $display("[TB] FAIL halt_hold: got pc %h valid %b halted %b want 2 0 1",
                                 bus.pc, bus.pc_valid, bus.halted);
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if ({bus.pc, bus.pc_valid, bus.halted} !== {64'h0, 2'b10}) begin
         nMismatched++; $display("[TB] FAIL halt_restart: got pc %h valid %b halted %b want 0 1 0",
                                 bus.pc, bus.pc_valid, bus.halted);
      end
      applyStimulus(0, 0, 1, 1, 1, 1, 64'h77);
      nCompared++;
      if (bus.pc !== 64'h0) begin
         nMismatched++; $display("[TB] FAIL stall_priority: got %h want %h", bus.pc, 64'h0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 64'h0);
      nCompared++;
      if (bus.pc !== 64'h1) begin
         nMismatched++; $display("[TB] FAIL after_stall: got %h want %h", bus.pc, 64'h1);
      end
   endtask

   task automatic test_wrap8();
      logic [3:0] retStatus;
      logic [3:0] haltStatus;
      retStatus  = RAS ? 4'b1001 : 4'b1000;
      haltStatus = RAS ? 4'b0101 : 4'b0100;
      applyStimulus8(1, 0, 0, 0, 0, 0, 8'h0);
      nCompared++;
      if ({bus8.pc, bus8.pc_valid} !== {8'h10, 1'b1}) begin
         nMismatched++; $display("[TB] FAIL w8_start: got pc %h valid %b want 10 1", bus8.pc, bus8.pc_valid);
      end
      applyStimulus8(0, 0, 0, 1, 0, 0, 8'hFF);
      applyStimulus8(0, 0, 0, 0, 0, 0, 8'h0);
      nCompared++;
      if ({bus8.pc, bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf} !== {8'h00, 4'b1000}) begin
         nMismatched++; $display("[TB] FAIL w8_wrap: got pc %h status %b want 00 1000", bus8.pc,
                                 {bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf});
      end
      applyStimulus8(0, 0, 0, 0, 0, 1, 8'h0);
      nCompared++;
      if ({bus8.pc, bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf} !== {8'h01, retStatus}) begin
         nMismatched++; $display("[TB] FAIL w8_ret_empty: got pc %h status %b want 01 %b", bus8.pc,
                                 {bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf}, retStatus);
      end
      applyStimulus8(0, 1, 0, 0, 0, 0, 8'h0);
      nCompared++;
      if ({bus8.pc, bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf} !== {8'h01, haltStatus}) begin
         nMismatched++; $display("[TB] FAIL w8_halt: got pc %h status %b want 01 %b", bus8.pc,
                                 {bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf}, haltStatus);
      end
      applyStimulus8(1, 0, 0, 0, 0, 0, 8'h0);
      nCompared++;
      if ({bus8.pc, bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf} !== {8'h10, 4'b1000}) begin
         nMismatched++; $display("[TB] FAIL w8_restart: got pc %h status %b want 10 1000", bus8.pc,
                                 {bus8.pc_valid, bus8.halted, bus8.ras_ovf, bus8.ras_unf});
      end
   endtask

   task automatic test_reset_midrun();
      reset = 1'b1;
      applyStimulus(1, 0, 0, 0, 0, 0, 64'h0);
      reset = 1'b0;
      nCompared++;
      if ({bus.pc, bus.pc_valid, bus.halted} !== {64'h0, 2'b00}) begin
         nMismatched++; $display("[TB] FAIL midrun_reset: got pc %h valid %b halted %b want 0 0 0",
                                 bus.pc, bus.pc_valid, bus.halted);
      end
      nCompared++;
      if ({bus8.pc, bus8.pc_valid} !== {8'h10, 1'b0}) begin
         nMismatched++; $display("[TB] FAIL midrun_reset8: got pc %h valid %b want 10 0", bus8.pc, bus8.pc_valid);
      end
      applyStimulus(0, 0, 0, 1, 0, 0, 64'h99);
      nCompared++;
      if ({bus.pc, bus.pc_valid} !== {64'h0, 1'b0}) begin
         nMismatched++; $display("[TB] FAIL post_reset_idle: got pc %h valid %b want 0 0", bus.pc, bus.pc_valid);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus8.start = 1'b0; bus8.end_req = 1'b0; bus8.stall = 1'b0;
      bus8.br_taken = 1'b0; bus8.call = 1'b0; bus8.ret = 1'b0; bus8.br_target = 8'h0;
      test_reset();
      test_run();
      test_branch_stall();
      test_call_ret();
      test_back_to_back();
      test_ras();
      test_halt();
      test_wrap8();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
